// File: rtl/deser_pkg.sv
// Shared types for the multi-lane deserializer.
//   state_t       : receive FSM states
//   MSB_FIRST_OFF : first beat carries the lowest word bits
//   MSB_FIRST_ON  : first beat carries the highest word bits
package deser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam bit MSB_FIRST_OFF = 1'b0;
  localparam bit MSB_FIRST_ON  = 1'b1;

endpackage

// File: rtl/deser_multilane_if.sv
// Serial-in / word-out bus of the multi-lane deserializer.
//   master : link + consumer side (drives serial_in, start, out_ready)
//   slave  : deserializer side (drives data_out, out_valid, status flags)
interface deser_multilane_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 1
);
  logic [LANES-1:0] serial_in;
  logic             start;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;
  logic             synced;
  logic             frame_err;
  logic             overflow;

  modport master (
    output serial_in, start, out_ready,
    input  data_out, out_valid, synced, frame_err, overflow
  );

  modport slave (
    input  serial_in, start, out_ready,
    output data_out, out_valid, synced, frame_err, overflow
  );
endinterface

// File: rtl/deser_fifo.sv
// First-word-fall-through word FIFO.
//   push/push_data : write request (accepted when not full, or full with pop)
//   pop            : consumer ready; pops only when a word is present
//   head_c         : oldest word, '0 when empty
//   valid_c        : FIFO not empty
//   drop_c         : push refused because full with no simultaneous pop
module deser_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             valid_c,
  output logic             drop_c
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q;
  logic             empty_c, full_c, pop_c, push_ok_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_c   = (occ_q == '0);
  assign full_c    = (occ_q == OCC_W'(FIFO_DEPTH));
  assign pop_c     = pop && !empty_c;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok_c = push && (!full_c || pop_c);
  assign drop_c    = push && full_c && !pop_c;

  assign valid_c = !empty_c;
  assign head_c  = empty_c ? '0 : mem_q[rd_ptr_q];

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_ok_c) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_c)     rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_ok_c && !pop_c)      occ_q <= occ_q + OCC_W'(1);
      else if (!push_ok_c && pop_c) occ_q <= occ_q - OCC_W'(1);
    end
  end

  // Storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/deser_multilane.sv
// Multi-lane start-framed deserializer with FWFT output buffering.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : serial_in/start in, data_out/out_valid/out_ready word handshake,
//                synced (receiving), frame_err (abort pulse), overflow (sticky drop)
module deser_multilane
  import deser_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LANES      = 1,
  parameter bit          MSB_FIRST  = MSB_FIRST_OFF,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic             clk,
  input logic             rst_n,
  deser_multilane_if.slave bus
);
  localparam int unsigned BEATS = WIDTH / LANES;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if ((WIDTH % LANES) != 0) begin : g_chk_width
    $error("deser_multilane: WIDTH must be a multiple of LANES");
  end
  if (FIFO_DEPTH < 1) begin : g_chk_depth
    $error("deser_multilane: FIFO_DEPTH must be at least 1");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_c;
  logic [LANES-1:0] beat_c;
  logic             frame_err_q, frame_err_d;
  logic             overflow_q;
  logic             push_c, drop_c;

  // Word assembly by shifting: after B beats every beat sits at its final position.
  if (MSB_FIRST) begin : g_msb
    // Lane j of a beat lands on the lower-numbered side, so lanes are reversed.
    for (genvar j = 0; j < LANES; j++) begin : g_rev
      assign beat_c[LANES-1-j] = bus.serial_in[j];
    end
    if (BEATS == 1) begin : g_one
      assign word_c = beat_c;
    end else begin : g_many
      assign word_c = {shift_q[WIDTH-LANES-1:0], beat_c};
    end
  end else begin : g_lsb
    assign beat_c = bus.serial_in;
    if (BEATS == 1) begin : g_one
      assign word_c = beat_c;
    end else begin : g_many
      assign word_c = {beat_c, shift_q[WIDTH-1:LANES]};
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_q | drop_c;
    end
  end

  // Next state; start always wins over completing the current word.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RECV;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      RECV: begin
        if (bus.start) begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          shift_d     = '0;
        end else begin
          shift_d = word_c;
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            push_c  = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  deser_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data (word_c),
    .pop       (bus.out_ready),
    .head_c    (bus.data_out),
    .valid_c   (bus.out_valid),
    .drop_c    (drop_c)
  );

  assign bus.synced    = (state_q == RECV);
  assign bus.frame_err = frame_err_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_deser_multilane.sv
// Bench for deser_multilane: a 1-lane LSB-first instance and a 2-lane MSB-first
// instance, table-driven frames plus hand-written multi-cycle sequences.
module tb_deser_multilane;
  import deser_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  deser_multilane_if #(.WIDTH(8), .LANES(1)) if1 ();
  deser_multilane_if #(.WIDTH(8), .LANES(2)) if2 ();

  deser_multilane #(
    .WIDTH(8), .LANES(1), .MSB_FIRST(MSB_FIRST_OFF), .FIFO_DEPTH(2)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  deser_multilane #(
    .WIDTH(8), .LANES(2), .MSB_FIRST(MSB_FIRST_ON), .FIFO_DEPTH(2)
  ) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2)
  );

  always #5 clk = ~clk;

  // cfg 1: seq[7] is the first bit on the wire (1-lane, LSB-first instance)
  // cfg 2: seq[2k+1:2k] is beat k as {lane1,lane0} (2-lane, MSB-first instance)
  typedef struct {
    int unsigned cfg;
    logic [7:0]  seq;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Start cycle plus 8 beats; counts out_valid and frame_err cycles seen on the way.
  task automatic send1(input logic [7:0] seq, output int vcnt, output int ecnt);
    vcnt = 0;
    ecnt = 0;
    if1.start = 1'b1;
    if (if1.out_valid) vcnt++;
    step();
    if1.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if1.serial_in = seq[7-k];
      chk("synced1_beat", 8'(if1.synced), 8'h01);
      if (if1.out_valid) vcnt++;
      if (if1.frame_err) ecnt++;
      step();
    end
    if1.serial_in = '0;
    chk("synced1_end", 8'(if1.synced), 8'h00);
  endtask

  task automatic send2(input logic [7:0] seq, output int vcnt, output int ecnt);
    vcnt = 0;
    ecnt = 0;
    if2.start = 1'b1;
    if (if2.out_valid) vcnt++;
    step();
    if2.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if2.serial_in = seq[2*k +: 2];
      chk("synced2_beat", 8'(if2.synced), 8'h01);
      if (if2.out_valid) vcnt++;
      if (if2.frame_err) ecnt++;
      step();
    end
    if2.serial_in = '0;
    chk("synced2_end", 8'(if2.synced), 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int v;
    int e;
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    if1.serial_in = '0; if1.start = 1'b0; if1.out_ready = 1'b1;
    if2.serial_in = '0; if2.start = 1'b0; if2.out_ready = 1'b1;

    vecs[0] = '{1, 8'hA5, 8'hA5};  // bits 1,0,1,0,0,1,0,1
    vecs[1] = '{1, 8'h80, 8'h01};  // only the first bit set
    vecs[2] = '{1, 8'h0F, 8'hF0};  // last four bits set
    vecs[3] = '{1, 8'hD0, 8'h0B};  // bits 1,1,0,1,0,0,0,0
    vecs[4] = '{2, 8'h3C, 8'h3C};  // beats 00,11,11,00
    vecs[5] = '{2, 8'h01, 8'h80};  // beat0 lane0 -> word[7]
    vecs[6] = '{2, 8'h02, 8'h40};  // beat0 lane1 -> word[6]
    vecs[7] = '{2, 8'h40, 8'h02};  // beat3 lane0 -> word[1]
    vecs[8] = '{2, 8'h80, 8'h01};  // beat3 lane1 -> word[0]
    vecs[9] = '{2, 8'h39, 8'h9C};  // beats 01,10,11,00

    #12;
    chk("rst_data",      if1.data_out,          8'h00);
    chk("rst_valid",     8'(if1.out_valid),     8'h00);
    chk("rst_synced",    8'(if1.synced),        8'h00);
    chk("rst_frame_err", 8'(if1.frame_err),     8'h00);
    chk("rst_overflow",  8'(if1.overflow),      8'h00);
    chk("rst_valid2",    8'(if2.out_valid),     8'h00);
    step();
    rst_n = 1'b1;
    step();

    // Single frames on both lane configurations.
    foreach (vecs[i]) begin
      if (vecs[i].cfg == 1) begin
        send1(vecs[i].seq, v, e);
        chk("vec_valid", 8'(if1.out_valid), 8'h01);
        chk("vec_data",  if1.data_out,      vecs[i].exp);
      end else begin
        send2(vecs[i].seq, v, e);
        chk("vec_valid", 8'(if2.out_valid), 8'h01);
        chk("vec_data",  if2.data_out,      vecs[i].exp);
      end
      chk("vec_early_valid", 8'(v), 8'h00);
      chk("vec_err",         8'(e), 8'h00);
      step();
      chk("vec_popped", 8'(vecs[i].cfg == 1 ? if1.out_valid : if2.out_valid), 8'h00);
    end

    // Back-to-back frames 0x12 then 0x34, no gap cycle.
    send1(8'h48, v, e);
    chk("b2b_valid0", 8'(if1.out_valid), 8'h01);
    chk("b2b_data0",  if1.data_out,      8'h12);
    send1(8'h2C, v, e);
    chk("b2b_single_beat", 8'(v), 8'h01);
    chk("b2b_valid1", 8'(if1.out_valid), 8'h01);
    chk("b2b_data1",  if1.data_out,      8'h34);
    step();
    chk("b2b_drained", 8'(if1.out_valid), 8'h00);

    // Stalled consumer: third word overflows a 2-deep FIFO.
    if1.out_ready = 1'b0;
    send1(8'h88, v, e);
    chk("ovf_data0", if1.data_out,      8'h11);
    chk("ovf_flag0", 8'(if1.overflow),  8'h00);
    send1(8'h44, v, e);
    chk("ovf_hold_cycles", 8'(v), 8'h09);
    chk("ovf_data1", if1.data_out,      8'h11);
    chk("ovf_flag1", 8'(if1.overflow),  8'h00);
    send1(8'hCC, v, e);
    chk("ovf_flag2", 8'(if1.overflow),  8'h01);
    chk("ovf_data2", if1.data_out,      8'h11);
    if1.out_ready = 1'b1;
    chk("drain_data0", if1.data_out, 8'h11);
    step();
    chk("drain_valid1", 8'(if1.out_valid), 8'h01);
    chk("drain_data1",  if1.data_out,      8'h22);
    step();
    chk("drain_empty",  8'(if1.out_valid), 8'h00);
    chk("drain_head0",  if1.data_out,      8'h00);
    step();
    chk("ovf_sticky",   8'(if1.overflow),  8'h01);

    // start after 3 beats aborts the partial frame.
    if1.start = 1'b1;
    step();
    if1.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if1.serial_in = 1'b1;
      step();
    end
    chk("abort_no_err_yet", 8'(if1.frame_err), 8'h00);
    send1(8'h0F, v, e);
    chk("abort_err_pulse", 8'(e), 8'h01);
    chk("abort_no_word",   8'(v), 8'h00);
    chk("abort_valid",     8'(if1.out_valid), 8'h01);
    chk("abort_data",      if1.data_out,      8'hF0);
    step();
    chk("abort_one_word",  8'(if1.out_valid), 8'h00);

    // start on the final-beat cycle discards that word.
    if1.start = 1'b1;
    step();
    if1.start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if1.serial_in = 1'b1;
      step();
    end
    send1(8'hA5, v, e);
    chk("last_abort_err",     8'(e), 8'h01);
    chk("last_abort_no_word", 8'(v), 8'h00);
    chk("last_abort_data",    if1.data_out, 8'hA5);
    step();
    chk("last_abort_one",     8'(if1.out_valid), 8'h00);

    // Asynchronous reset mid-frame with one word buffered.
    if1.out_ready = 1'b0;
    send1(8'h88, v, e);
    chk("pre_rst_valid", 8'(if1.out_valid), 8'h01);
    if1.start = 1'b1;
    step();
    if1.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if1.serial_in = 1'b1;
      step();
    end
    rst_n = 1'b0;
    #2;
    chk("arst_valid",    8'(if1.out_valid), 8'h00);
    chk("arst_data",     if1.data_out,      8'h00);
    chk("arst_synced",   8'(if1.synced),    8'h00);
    chk("arst_overflow", 8'(if1.overflow),  8'h00);
    chk("arst_err",      8'(if1.frame_err), 8'h00);
    rst_n = 1'b1;
    if1.serial_in = 1'b0;
    step();
    if1.out_ready = 1'b1;
    send1(8'h5A, v, e);
    chk("post_rst_no_old", 8'(v), 8'h00);
    chk("post_rst_valid",  8'(if1.out_valid), 8'h01);
    chk("post_rst_data",   if1.data_out,      8'h5A);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
